// File: rtl/scratch_mem_rr_ctrl.sv
// Shared scratch RAM for N_CH requesters: round-robin write and read arbiters,
// a zero-fill engine (on reset and on demand) and a per-channel read-valid return.
//
//   state    | meaning
//   ST_IDLE  | arbiters active, grants issued
//   ST_CLEAR | zero-fill sweep in progress, busy_o=1, no grants
module scratch_mem_rr_ctrl #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 11,
   parameter int N_CH           = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     clear_i,
   output logic                     busy_o,
   input  logic [N_CH-1:0]          wr_req_i,
   input  logic [N_CH*ADDR_W-1:0]   wr_addr_i,
   input  logic [N_CH*DATA_W-1:0]   wr_data_i,
   output logic [N_CH-1:0]          wr_gnt_o,
   input  logic [N_CH-1:0]          rd_req_i,
   input  logic [N_CH*ADDR_W-1:0]   rd_addr_i,
   output logic [N_CH-1:0]          rd_gnt_o,
   output logic [N_CH-1:0]          rd_valid_o,
   output logic [DATA_W-1:0]        rd_data_o
);

   localparam int PTR_W = $clog2(N_CH);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   clr_cnt_q;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [N_CH-1:0]     rd_valid_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                arb_en;
   logic [PTR_W:0]      wr_pick, rd_pick;
   logic                wr_en, rd_en;
   logic [PTR_W-1:0]    wr_idx, rd_idx;
   logic [ADDR_W-1:0]   wr_addr_sel, rd_addr_sel;
   logic [DATA_W-1:0]   wr_data_sel;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [DATA_W-1:0]   ram_wdata;

   // First requester at or above ptr (mod N_CH); MSB of result flags a hit.
   function automatic logic [PTR_W:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [PTR_W-1:0] ptr);
      logic [PTR_W:0] res;
      int             idx;
      res = '0;
      for (int k = N_CH-1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (req[idx]) res = {1'b1, PTR_W'(idx)};
      end
      return res;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
      return (idx == PTR_W'(N_CH-1)) ? '0 : idx + PTR_W'(1);
   endfunction

   // Grants are combinational so a write commits on the same edge it is granted;
   // a reset cycle never grants, so nothing commits while reset is sampled.
   assign arb_en = (state_q == ST_IDLE) && !reset_i;

   // Arbitration, grant vectors and selected port data.
   always_comb begin
      wr_pick     = rr_pick(wr_req_i, wr_ptr_q);
      rd_pick     = rr_pick(rd_req_i, rd_ptr_q);
      wr_en       = arb_en && wr_pick[PTR_W];
      rd_en       = arb_en && rd_pick[PTR_W];
      wr_idx      = wr_pick[PTR_W-1:0];
      rd_idx      = rd_pick[PTR_W-1:0];
      wr_gnt_o    = wr_en ? (N_CH'(1) << wr_idx) : '0;
      rd_gnt_o    = rd_en ? (N_CH'(1) << rd_idx) : '0;
      wr_ptr_d    = ptr_after(wr_idx);
      rd_ptr_d    = ptr_after(rd_idx);
      wr_addr_sel = wr_addr_i[int'(wr_idx)*ADDR_W +: ADDR_W];
      wr_data_sel = wr_data_i[int'(wr_idx)*DATA_W +: DATA_W];
      rd_addr_sel = rd_addr_i[int'(rd_idx)*ADDR_W +: ADDR_W];
      ram_we      = !reset_i && ((state_q == ST_CLEAR) || wr_en);
      ram_waddr   = (state_q == ST_CLEAR) ? clr_cnt_q : wr_addr_sel;
      ram_wdata   = (state_q == ST_CLEAR) ? '0 : wr_data_sel;
   end

   // Control FSM, clear counter and round-robin pointers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         clr_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clear_i) state_q <= ST_CLEAR;
            end
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == '1) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
         if (wr_en) wr_ptr_q <= wr_ptr_d;
         if (rd_en) rd_ptr_q <= rd_ptr_d;
      end
   end

   // RAM port A: zero-fill during the sweep, otherwise the granted write.
   always_ff @(posedge clk_i) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
   end

   // RAM port B: read-first registered read; data holds when nothing is granted.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_gnt_o;
         if (rd_en) rd_data_q <= mem[rd_addr_sel];
      end
   end

   assign busy_o     = (state_q == ST_CLEAR);
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;

endmodule
